// File: rtl/neuron_loader.sv
// Host-side sequencer for the neuron array: streams the load protocol from a
// valid/ready config stream, runs annealing rounds and buffers readouts in a FIFO.
module neuron_loader #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int NEURON_ID_WIDTH = 9,
    parameter int RUN_CNT_WIDTH   = 16,
    parameter int RD_FIFO_DEPTH   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NEURON_ID_WIDTH-1:0] active_neurons,
    input  logic [RUN_CNT_WIDTH-1:0]   run_cycles,
    input  logic [7:0]                 num_rounds,
    input  logic [FP_DATA_WIDTH-1:0]   mu_ext,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [FP_DATA_WIDTH-1:0]   cfg_data,
    output logic [FP_DATA_WIDTH-1:0]   ins,
    output logic                       rd,
    input  logic [FP_DATA_WIDTH-1:0]   outs,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [FP_DATA_WIDTH-1:0]   rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int AW   = $clog2(RD_FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int SW   = NEURON_ID_WIDTH + 2;
    localparam int CW   = (CNTW > 6) ? CNTW : 6;
    localparam logic [NEURON_ID_WIDTH-1:0] N_MAX = {{(NEURON_ID_WIDTH-1){1'b1}}, 1'b0};

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SEND_N    = 4'd1;
    localparam logic [3:0] S_SEND_SYNC = 4'd2;
    localparam logic [3:0] S_LOAD      = 4'd3;
    localparam logic [3:0] S_RUN       = 4'd4;
    localparam logic [3:0] S_RD_REQ    = 4'd5;
    localparam logic [3:0] S_RD_CAP    = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    logic [3:0]                 state;
    logic [NEURON_ID_WIDTH-1:0] n_reg;
    logic [RUN_CNT_WIDTH-1:0]   r_reg;
    logic [RUN_CNT_WIDTH-1:0]   run_cnt;
    logic [7:0]                 k_reg;
    logic [7:0]                 round_cnt;
    logic [SW-1:0]              slot;
    logic [5:0]                 cap_cnt;

    logic [FP_DATA_WIDTH-1:0] mem [RD_FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CNTW-1:0]          fifo_cnt;

    logic          start_ok;
    logic [5:0]    w;
    logic [SW-1:0] last_slot;
    logic [CW-1:0] free;
    logic          room;
    logic          run_reached;
    logic          push;
    logic          pop;

    assign start_ok    = (active_neurons != '0) && (active_neurons <= N_MAX) &&
                         (run_cycles != '0) && (num_rounds != 8'd0);
    assign w           = 6'(n_reg >> 4) + 6'd1;
    assign last_slot   = {n_reg, 2'b00} - SW'(1);
    assign free        = CW'(RD_FIFO_DEPTH) - CW'(fifo_cnt);
    // A readout is only requested once its whole burst is guaranteed to fit.
    assign room        = free >= CW'(w);
    assign run_reached = run_cnt >= (r_reg - RUN_CNT_WIDTH'(1));
    assign push        = (state == S_RD_CAP);
    assign pop         = rd_valid && rd_ready;

    assign cfg_ready = (state == S_LOAD);
    assign rd        = (state == S_RD_REQ);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign busy      = (state != S_IDLE) && (state != S_ERR);
    assign rd_valid  = (fifo_cnt != '0);
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

    always_comb begin
        ins = '0;
        case (state)
            S_SEND_N:    ins = FP_DATA_WIDTH'(n_reg);
            S_SEND_SYNC: ins = '1;
            S_LOAD:      ins = cfg_valid ? cfg_data : '0;
            S_RUN, S_RD_REQ, S_RD_CAP, S_DONE: ins = mu_ext;
            default:     ins = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            n_reg     <= '0;
            r_reg     <= '0;
            k_reg     <= '0;
            run_cnt   <= '0;
            round_cnt <= '0;
            slot      <= '0;
            cap_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    n_reg     <= active_neurons;
                    r_reg     <= run_cycles;
                    k_reg     <= num_rounds;
                    run_cnt   <= '0;
                    round_cnt <= '0;
                    slot      <= '0;
                    state     <= start_ok ? S_SEND_N : S_ERR;
                end
                S_SEND_N:    state <= S_SEND_SYNC;
                S_SEND_SYNC: state <= S_LOAD;
                S_LOAD: begin
                    // The array has no stall, so a missing word is fatal.
                    if (!cfg_valid) begin
                        state <= S_ERR;
                    end else if (slot == last_slot) begin
                        slot    <= '0;
                        run_cnt <= '0;
                        state   <= S_RUN;
                    end else begin
                        slot <= slot + SW'(1);
                    end
                end
                S_RUN: begin
                    if (!run_reached) run_cnt <= run_cnt + RUN_CNT_WIDTH'(1);
                    else if (room)    state   <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    cap_cnt <= '0;
                    state   <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    if (cap_cnt == w - 6'd1) begin
                        round_cnt <= round_cnt + 8'd1;
                        run_cnt   <= '0;
                        state     <= (round_cnt + 8'd1 == k_reg) ? S_DONE : S_RUN;
                    end else begin
                        cap_cnt <= cap_cnt + 6'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= outs;
    end
endmodule

// File: tb/tb_neuron_loader.sv
// Bench for neuron_loader: start-validity table, protocol sessions against a
// timing/data model, underflow, FIFO back-pressure and reset-abort sequences.
module tb_neuron_loader;
    logic        clk = 1'b0;
    logic        reset, start, cfg_valid, cfg_ready, rd, rd_valid, rd_ready;
    logic        busy, done, err;
    logic [8:0]  active_neurons;
    logic [15:0] run_cycles, mu_ext, cfg_data, ins, outs, rd_data;
    logic [7:0]  num_rounds;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          rd_times[$];
    int          done_times[$];
    logic [15:0] exp_rd[$];
    int          cur_w = 1;
    bit          pat_mode = 1'b0;
    int          pat_idx = 0;
    logic [15:0] pattern [3];

    typedef struct { int n; int r; int k; bit bad; } vec_t;
    vec_t tbl [7];

    neuron_loader dut (
        .clk(clk), .reset(reset), .start(start), .active_neurons(active_neurons),
        .run_cycles(run_cycles), .num_rounds(num_rounds), .mu_ext(mu_ext),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .ins(ins), .rd(rd), .outs(outs), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Event monitor: cycle index of every rd and done pulse.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (rd)   rd_times.push_back(cyc);
            if (done) done_times.push_back(cyc);
        end
    end

    // Array model: after an rd pulse, present W words on outs, junk otherwise.
    initial begin
        logic [15:0] wv;
        outs = 16'h1234;
        forever begin
            @(negedge clk);
            if (rd === 1'b1 && !reset) begin
                for (int i = 0; i < cur_w; i++) begin
                    @(posedge clk); #1;
                    wv = pat_mode ? pattern[pat_idx % 3] : 16'($urandom);
                    pat_idx++;
                    outs = wv;
                    exp_rd.push_back(wv);
                end
                @(posedge clk); #1;
                outs = 16'($urandom);
            end
        end
    end

    // Host-side scoreboard on the readout stream.
    initial forever begin
        @(negedge clk);
        if (!reset && rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data_extra: got %0h expected no word", rd_data);
            end else begin
                chk("rd_data", rd_data, exp_rd.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd.delete(); rd_times.delete(); done_times.delete();
    endtask

    task automatic pulse_start(input int n, input int r, input int k, output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        active_neurons = 9'(n); run_cycles = 16'(r); num_rounds = 8'(k);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        active_neurons = 9'($urandom); run_cycles = 16'($urandom_range(1, 9));
        num_rounds = 8'($urandom);
    endtask

    // Start plus full load, checking the ins word stream. Returns in the first RUN cycle.
    task automatic start_load(input int n, input int r, input int k, input bit seq_cfg, output int t0);
        logic [15:0] wv;
        pulse_start(n, r, k, t0);
        @(negedge clk);
        chk("send_n_ins", ins, n);
        chk("send_n_busy", busy, 1);
        @(negedge clk);
        chk("sync_ins", ins, 16'hFFFF);
        for (int i = 0; i < 4 * n; i++) begin
            @(posedge clk); #1;
            wv = seq_cfg ? 16'(32'h0100 + i) : 16'($urandom);
            cfg_valid = 1'b1;
            cfg_data  = wv;
            @(negedge clk);
            chk("load_ins", ins, wv);
            chk("load_cfg_ready", cfg_ready, 1);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_data  = 16'($urandom);
    endtask

    // Full session with rd_ready held high; rd/done timing from plain arithmetic.
    task automatic session(input int n, input int r, input int k, input bit seq_cfg, input bit pat);
        int t0, w, r0, lim;
        logic [15:0] mu;
        do_reset();
        w = n / 16 + 1;
        cur_w = w; pat_mode = pat; pat_idx = 0; rd_ready = 1'b1;
        mu = 16'($urandom); mu_ext = mu;
        start_load(n, r, k, seq_cfg, t0);
        for (int j = 0; j < r; j++) begin
            @(negedge clk);
            chk("run_ins", ins, mu);
            chk("run_rd", rd, 0);
        end
        lim = k * (w + r + 2) + 20;
        while (done_times.size() == 0 && lim > 0) begin
            @(negedge clk); #2;
            lim--;
        end
        if (lim == 0) bound_fail("session_done");
        repeat (w + 4) @(negedge clk);
        #2;
        r0 = t0 + 3 + 4 * n + r;
        chk("rd_count", rd_times.size(), k);
        for (int i = 0; i < k && i < rd_times.size(); i++)
            chk("rd_time", rd_times[i], r0 + i * (w + r + 1));
        chk("done_count", done_times.size(), 1);
        if (done_times.size() > 0)
            chk("done_time", done_times[0], r0 + (k - 1) * (w + r + 1) + w + 1);
        chk("fifo_drained", exp_rd.size(), 0);
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int t0, lim, stall_rd;
        logic [15:0] mu;

        pattern[0] = 16'hA5A5; pattern[1] = 16'h5A5A; pattern[2] = 16'h0F0F;
        tbl[0] = '{0, 4, 1, 1'b1};
        tbl[1] = '{511, 4, 1, 1'b1};
        tbl[2] = '{3, 0, 1, 1'b1};
        tbl[3] = '{3, 4, 0, 1'b1};
        tbl[4] = '{510, 1, 1, 1'b0};
        tbl[5] = '{1, 1, 1, 1'b0};
        tbl[6] = '{5, 65535, 255, 1'b0};

        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; rd_ready = 1'b0;
        active_neurons = '0; run_cycles = '0; num_rounds = '0; mu_ext = 16'h3C3C;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ins", ins, 0);       chk("rst_rd", rd, 0);
        chk("rst_cfg_ready", cfg_ready, 0); chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);     chk("rst_err", err, 0);

        // Start-parameter validity table.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            pulse_start(tbl[i].n, tbl[i].r, tbl[i].k, t0);
            @(negedge clk);
            chk("tbl_err", err, tbl[i].bad);
            chk("tbl_busy", busy, !tbl[i].bad);
            chk("tbl_ins1", ins, tbl[i].bad ? 0 : tbl[i].n);
            chk("tbl_cfg_ready", cfg_ready, 0);
            @(negedge clk);
            chk("tbl_ins2", ins, tbl[i].bad ? 0 : 16'hFFFF);
        end

        session(3, 4, 1, 1'b1, 1'b0);
        session(40, 3, 2, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            session($urandom_range(1, 70), $urandom_range(1, 6), $urandom_range(1, 3), 1'b0, 1'b0);

        // Underflow: cfg_valid dropped at slot 5 of N=2.
        do_reset();
        pulse_start(2, 3, 1, t0);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cfg_valid = (i != 5);
            cfg_data  = 16'($urandom);
            @(negedge clk);
            chk("uf_cfg_ready", cfg_ready, 1);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("uf_err", err, 1); chk("uf_cfg_ready_low", cfg_ready, 0);
        chk("uf_busy", busy, 0); chk("uf_ins", ins, 0); chk("uf_rd", rd, 0);
        cfg_valid = 1'b0;
        pulse_start(2, 3, 1, t0);
        @(negedge clk);
        @(negedge clk);
        chk("uf_start_ignored_err", err, 1);
        chk("uf_start_ignored_busy", busy, 0);
        chk("uf_start_ignored_ins", ins, 0);

        // Back-pressure: N=510 gives W=32, a full FIFO blocks round 2.
        do_reset();
        cur_w = 32; pat_mode = 1'b0; pat_idx = 0;
        mu = 16'($urandom); mu_ext = mu;
        start_load(510, 2, 2, 1'b0, t0);
        lim = 100;
        while (!(exp_rd.size() == 32 && rd_valid) && lim > 0) begin
            @(negedge clk); #2;
            lim--;
        end
        if (lim == 0) bound_fail("fill_round1");
        stall_rd = 0;
        repeat (200) begin
            @(negedge clk);
            if (rd) stall_rd++;
        end
        chk("fill_no_rd", stall_rd, 0);
        chk("fill_rd_count", rd_times.size(), 1);
        chk("fill_busy", busy, 1);
        chk("fill_ins_mu", ins, mu);
        chk("fill_rd_valid", rd_valid, 1);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        lim = 100;
        while (exp_rd.size() > 1 && lim > 0) begin
            @(negedge clk); #2;
            lim--;
        end
        if (lim == 0) bound_fail("fill_drain");
        chk("fill_held_rd", rd, 0);
        chk("fill_held_count", rd_times.size(), 1);
        lim = 200;
        while (done_times.size() == 0 && lim > 0) begin
            @(negedge clk); #2;
            lim--;
        end
        if (lim == 0) bound_fail("fill_done");
        repeat (36) @(negedge clk);
        #2;
        chk("fill_rd_total", rd_times.size(), 2);
        chk("fill_done_count", done_times.size(), 1);
        chk("fill_drained", exp_rd.size(), 0);

        // Reset mid-LOAD with a non-empty FIFO: everything returns to reset values.
        do_reset();
        cur_w = 1; pat_mode = 1'b0;
        start_load(3, 1, 2, 1'b0, t0);
        lim = 60;
        while (done_times.size() == 0 && lim > 0) begin
            @(negedge clk); #2;
            lim--;
        end
        if (lim == 0) bound_fail("flush_done");
        repeat (3) @(negedge clk);
        chk("flush_pre_rd_valid", rd_valid, 1);
        pulse_start(5, 2, 1, t0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_data = 16'($urandom);
        @(negedge clk);
        chk("mid_load_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_data = 16'($urandom);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_ins", ins, 0);       chk("abort_rd", rd, 0);
        chk("abort_cfg_ready", cfg_ready, 0); chk("abort_rd_valid", rd_valid, 0);
        chk("abort_rd_data", rd_data, 0); chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);     chk("abort_err", err, 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
